// File: rtl/rv32i_pkg.sv
// Shared constants and types for the RV32I fetch stage.
package rv32i_pkg;

  localparam logic [31:0] NOP_IW     = 32'h0000_0013;
  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] iw;
  } fetch_entry_t;

  // True for ECALL/EBREAK and the rest of the SYSTEM major opcode
  function automatic logic is_system(input logic [31:0] iw);
    return (iw[6:0] == OPC_SYSTEM);
  endfunction

endpackage

// File: rtl/rv32i_fetch_chk.sv
// Safety checks for the fetch stage; credit accounting must make a push into a full FIFO impossible.
module rv32i_fetch_chk (
  input logic clk,
  input logic reset,
  input logic fifo_push,
  input logic fifo_full
);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(fifo_push && fifo_full));

endmodule

// File: rtl/rv32i_fetch_fifo.sv
// Circular-buffer FIFO of fetched {pc, iw} pairs; flush empties it in one cycle.
module rv32i_fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1'b1);
    end
  endfunction

  // Pointers and occupancy; flush has priority over push and pop
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_r + CW'(push) - CW'(pop);
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {$bits(fetch_entry_t){1'b0}};
      end
    end else if (push && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == {CW{1'b0}});
  assign full  = (count_r == CW'(DEPTH));

endmodule

// File: rtl/rv32i_fetch_stage.sv
// RV32I instruction-fetch stage: credit-limited in-order imem reads, redirect
// squash of in-flight words, and a sticky halt on SYSTEM instructions.
module rv32i_fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump_en_in,
  input  logic [31:0] jump_addr_in,
  input  logic        stall_in,
  output logic        imem_rd,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  output logic [31:0] pc_out,
  output logic [31:0] iw_out,
  output logic        jump_en_out,
  output logic        halt_out
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t  state_r;
  fetch_state_t  state_next_s;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   resp_pc_r;
  logic [31:0]   target_pc_s;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] drop_r;
  logic [CW-1:0] fifo_count_s;
  logic [CW:0]   in_flight_s;
  logic [31:0]   pc_r;
  logic [31:0]   iw_r;
  logic          jump_en_r;
  logic          halt_r;
  logic          running_s;
  logic          redirect_s;
  logic          issue_s;
  logic          resp_keep_s;
  logic          deliver_s;
  logic          bypass_s;
  logic          out_valid_s;
  logic          fifo_push_s;
  logic          fifo_pop_s;
  logic          fifo_flush_s;
  logic          fifo_empty_s;
  logic          fifo_full_s;
  fetch_entry_t  resp_entry_s;
  fetch_entry_t  fifo_head_s;
  fetch_entry_t  out_entry_s;
  logic [1:0]    unused_addr_lsb_s;

  assign target_pc_s       = {jump_addr_in[31:2], 2'b00};
  assign unused_addr_lsb_s = jump_addr_in[1:0];
  assign resp_entry_s      = {resp_pc_r, imem_data};
  // Stale words still in flight count against credit until they come back
  assign in_flight_s       = {1'b0, outstanding_r} + {1'b0, fifo_count_s};

  // Issue gating, response routing and selection of the word handed to decode
  always_comb begin
    running_s    = (state_r == RUN);
    redirect_s   = running_s && jump_en_in;
    issue_s      = running_s && !reset && !jump_en_in && (in_flight_s < (CW+1)'(DEPTH));
    resp_keep_s  = running_s && !jump_en_in && imem_valid && (drop_r == {CW{1'b0}});
    deliver_s    = running_s && !jump_en_in && !stall_in;
    bypass_s     = deliver_s && fifo_empty_s && resp_keep_s;
    fifo_push_s  = resp_keep_s && !bypass_s;
    fifo_pop_s   = deliver_s && !fifo_empty_s;
    fifo_flush_s = redirect_s || !running_s;
    out_valid_s  = fifo_pop_s || bypass_s;
    if (fifo_pop_s) begin
      out_entry_s = fifo_head_s;
    end else begin
      out_entry_s = resp_entry_s;
    end
  end

  // Next state: halt once a SYSTEM instruction reaches decode; only reset leaves HALT
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (out_valid_s && is_system(out_entry_s.iw)) begin
          state_next_s = HALT;
        end else begin
          state_next_s = RUN;
        end
      end
      HALT:    state_next_s = HALT;
      default: state_next_s = RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Fetch and response PCs plus the outstanding/drop counters
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      drop_r        <= {CW{1'b0}};
    end else begin
      outstanding_r <= outstanding_r + CW'(issue_s) - CW'(imem_valid);
      if (redirect_s) begin
        fetch_pc_r <= target_pc_s;
        resp_pc_r  <= target_pc_s;
        drop_r     <= outstanding_r - CW'(imem_valid);
      end else begin
        fetch_pc_r <= issue_s ? (fetch_pc_r + 32'd4) : fetch_pc_r;
        resp_pc_r  <= resp_keep_s ? (resp_pc_r + 32'd4) : resp_pc_r;
        if (imem_valid && (drop_r != {CW{1'b0}})) begin
          drop_r <= drop_r - CW'(1'b1);
        end else begin
          drop_r <= drop_r;
        end
      end
    end
  end

  // Decode-facing output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r      <= 32'h0000_0000;
      iw_r      <= NOP_IW;
      jump_en_r <= 1'b0;
      halt_r    <= 1'b0;
    end else begin
      jump_en_r <= redirect_s;
      halt_r    <= (state_next_s == HALT);
      if (!running_s || redirect_s) begin
        iw_r <= NOP_IW;
      end else if (stall_in) begin
        iw_r <= iw_r;
      end else if (out_valid_s) begin
        pc_r <= out_entry_s.pc;
        iw_r <= out_entry_s.iw;
      end else begin
        iw_r <= NOP_IW;
      end
    end
  end

  rv32i_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push_s),
    .push_data (resp_entry_s),
    .pop       (fifo_pop_s),
    .flush     (fifo_flush_s),
    .head      (fifo_head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  rv32i_fetch_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .fifo_push (fifo_push_s),
    .fifo_full (fifo_full_s)
  );

  assign imem_rd     = issue_s;
  assign imem_addr   = fetch_pc_r;
  assign pc_out      = pc_r;
  assign iw_out      = iw_r;
  assign jump_en_out = jump_en_r;
  assign halt_out    = halt_r;

endmodule

// File: doc/rv32i_fetch_stage.md
Name: rv32i_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage RV32I pipeline. It is the consuming end of the decode stage's jump_en/jump_addr redirect interface, and the producer of pc/iw into decode. It issues in-order word reads to instruction memory with variable latency and buffers returned words in a small FIFO. On a redirect it discards stale in-flight responses, and it halts on a SYSTEM opcode.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, fetch FIFO entries; also the maximum credit of outstanding-plus-buffered words

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
jump_en_in  in  1  redirect request from decode
jump_addr_in  in  32  redirect target from decode
stall_in  in  1  hold the decode-facing outputs
imem_rd  out  1  read request, one word per asserted cycle
imem_addr  out  32  word-aligned read address
imem_valid  in  1  read data valid; responses return in request order
imem_data  in  32  read data
pc_out  out  32  PC of iw_out (to decode)
iw_out  out  32  instruction word (to decode)
jump_en_out  out  1  one-cycle pulse: the redirect was taken last cycle (decode uses it to suppress a re-jump)
halt_out  out  1  sticky halt indicator

Behaviour:
- Reset, checked every clock edge with priority over everything:
  - fetch_pc <= RESET_PC; FIFO empty; outstanding count 0; drop count 0; state RUN.
  - iw_out <= NOP (32'h13); pc_out <= 0; jump_en_out <= 0; halt_out <= 0; imem_rd = 0.
- Reset mid-operation takes effect at the next edge; nothing issued before reset is kept.
- Credit rule: outstanding + fifo_count + (valid responses not being dropped) <= DEPTH at all times.
- Issue: imem_rd = 1 iff state==RUN && !jump_en_in && credit available. imem_addr = fetch_pc. fetch_pc += 4 on each issue, wrapping modulo 2^32.
- Response: on imem_valid, decrement outstanding.
  - If drop_count>0, decrement drop_count and discard the data.
  - Otherwise push {pc, data}; the pc is tracked by a separate response-pc counter.
- Output, when !stall_in and there is no redirect:
  - FIFO non-empty: pop to pc_out/iw_out.
  - FIFO empty: iw_out <= NOP and pc_out holds.
- stall_in=1: pc_out/iw_out hold. Issue continues until credit is exhausted.
- Redirect (jump_en_in=1) wins over stall_in and over a pop. In that cycle:
  - Flush the FIFO; drop_count <= outstanding minus any valid response arriving that cycle.
  - fetch_pc and response pc <= {jump_addr_in[31:2],2'b00}.
  - iw_out <= NOP; jump_en_out <= 1 for exactly one cycle.
  - No issue in the redirect cycle; fetch from the target starts next cycle, giving a redirect-to-target-fetch latency of 1.
- States:
  - RUN -> HALT when the popped iw has opcode 7'b1110011 (EBREAK/ECALL).
  - The SYSTEM instruction itself is delivered to iw_out.
  - HALT: halt_out=1, imem_rd=0, every subsequent output is NOP, jump_en_in is ignored, responses are drained and discarded.
  - Only reset leaves HALT.
- Minimum latency from imem_valid to iw_out is 1 cycle (push then pop in the same cycle when the FIFO is empty: bypass permitted, registered output).
- The empty/full boundary is controlled solely by credit. A push when full is impossible; an assertion checks it.

Decomposition:
- Package rv32i_pkg:
  - NOP_IW = 32'h13.
  - OPC_SYSTEM = 7'b1110011.
  - typedef enum {RUN, HALT} fetch_state_t.
  - typedef struct {pc, iw} fetch_entry_t.
- Sub-module rv32i_fetch_fifo: parameterised DEPTH, synchronous-reset FIFO with push, pop, flush, count, and an empty/full indicator.

Test Plan:
1. Reset, then 1-cycle-latency imem returning data = addr ^ 32'hA5A5_0000 -> imem_addr is 0, 4, 8...; pc_out/iw_out sequence 0/A5A5_0000, 4/A5A5_0004, 8/A5A5_0008; jump_en_out stays 0.
2. Memory latency 3 with two requests outstanding, then jump_en_in=1 with addr 0x100 -> both stale responses are dropped; jump_en_out is high for one cycle; the next non-NOP iw_out has pc_out=0x100.
3. stall_in held 4 cycles with a 1-cycle memory -> pc_out/iw_out are constant; imem_rd deasserts after 2 issues (DEPTH=2); after release, the words emerge in order with no loss.
4. Memory returns 0x00100073 at pc 0xC -> iw_out=0x00100073, pc_out=0xC; then halt_out=1, imem_rd=0 forever, and iw_out=NOP thereafter. A later jump_en_in is ignored.
5. jump_en_in and stall_in asserted together with addr 0x203 -> imem_addr=0x200 next cycle; iw_out=NOP.
6. Reset asserted mid-stream with a response pending -> the next cycle shows reset values on all outputs, and the first imem_addr after reset is RESET_PC.
